// File: rtl/sp_ram_sync.sv
// Single-port synchronous RAM with request/response handshake, a full-memory
// clear state machine (runs after reset and on clear_req), an optional
// read-on-write response (RD_ON_WR), and optional per-word even parity
// enabled by the macro SP_RAM_PARITY_EN.
module sp_ram_sync #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned RD_ON_WR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              inj_perr,
    input  logic              clear_req,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_perr,
    output logic              init_busy
);

    localparam int unsigned DEPTH = 2**ADDR_W;
`ifdef SP_RAM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_addr;
    logic              accept_c;
    logic              respond_c;
    logic [MEM_W-1:0]  wr_word_c;
    logic [MEM_W-1:0]  rd_word_c;
    logic              rd_perr_c;
    logic [MEM_W-1:0]  mem [DEPTH];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: clear sweeps every address once; clear_req only honoured in READY
    always_comb begin
        state_nxt = state;
        unique case (state)
            INIT:    if (clr_addr == {ADDR_W{1'b1}}) state_nxt = READY;
            READY:   if (clear_req) state_nxt = INIT;
            default: state_nxt = INIT;
        endcase
    end

    // FSM outputs and request acceptance
    always_comb begin
        req_ready = 1'b0;
        init_busy = 1'b0;
        unique case (state)
            INIT:    init_busy = 1'b1;
            READY:   req_ready = !clear_req;
            default: init_busy = 1'b1;
        endcase
        accept_c  = req_valid && req_ready;
        respond_c = accept_c && (!req_we || (RD_ON_WR != 0));
    end

    // Clear address walks 0..DEPTH-1 while in INIT, then wraps back to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr <= '0;
        end else if (state == INIT) begin
            clr_addr <= clr_addr + ADDR_W'(1);
        end else if (clear_req) begin
            clr_addr <= '0;
        end
    end

    // Stored word formation and read-side parity check
`ifdef SP_RAM_PARITY_EN
    always_comb begin
        wr_word_c = {(^req_wdata) ^ inj_perr, req_wdata};
        rd_word_c = mem[req_addr];
        rd_perr_c = ^rd_word_c;
    end
`else
    logic unused_inj_perr;
    assign unused_inj_perr = inj_perr;

    always_comb begin
        wr_word_c = req_wdata;
        rd_word_c = mem[req_addr];
        rd_perr_c = 1'b0;
    end
`endif

    // Memory array: clear writes zero (parity of zero is zero), else accepted writes
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[clr_addr] <= '0;
        end else if (accept_c && req_we) begin
            mem[req_addr] <= wr_word_c;
        end
    end

    // Response register: one-cycle strobe, data holds between responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_perr  <= 1'b0;
        end else begin
            rsp_valid <= respond_c;
            if (respond_c) begin
                rsp_rdata <= rd_word_c[DATA_W-1:0];
                rsp_perr  <= rd_perr_c;
            end else begin
                rsp_perr  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sp_ram_sync.sv
// Bench for sp_ram_sync: two instances (RD_ON_WR=0 and RD_ON_WR=1) share the
// same stimulus and are compared against a behavioural memory model.
module tb_sp_ram_sync;

    localparam int DEPTH = 16;
`ifdef SP_RAM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_we;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       inj_perr;
    logic       clear_req;

    logic       req_ready0, req_ready1;
    logic       rsp_valid0, rsp_valid1;
    logic [7:0] rsp_rdata0, rsp_rdata1;
    logic       rsp_perr0, rsp_perr1;
    logic       init_busy0, init_busy1;

    always #5 clk = ~clk;

    sp_ram_sync #(.DATA_W(8), .ADDR_W(4), .RD_ON_WR(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .inj_perr(inj_perr), .clear_req(clear_req), .rsp_valid(rsp_valid0),
        .rsp_rdata(rsp_rdata0), .rsp_perr(rsp_perr0), .init_busy(init_busy0)
    );

    sp_ram_sync #(.DATA_W(8), .ADDR_W(4), .RD_ON_WR(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .inj_perr(inj_perr), .clear_req(clear_req), .rsp_valid(rsp_valid1),
        .rsp_rdata(rsp_rdata1), .rsp_perr(rsp_perr1), .init_busy(init_busy1)
    );

    // Behavioural model state
    logic [7:0] m_mem [DEPTH];
    bit         m_pinj [DEPTH];
    bit         m_ready;
    int         m_init_left;
    bit         e0v, e1v, e0p, e1p;
    logic [7:0] e0d, e1d;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit         we;
        logic [3:0] addr;
        logic [7:0] wdata;
        bit         inj;
        logic [7:0] rdata;
        bit         perr;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_wipe();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = 8'h00;
            m_pinj[i] = 1'b0;
        end
    endtask

    // Asynchronous reset: outputs must take reset values without a clock edge
    task automatic do_reset();
        req_valid = 1'b0;
        clear_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_busy0", init_busy0, 1);
        chk("rst_busy1", init_busy1, 1);
        chk("rst_ready0", req_ready0, 0);
        chk("rst_ready1", req_ready1, 0);
        chk("rst_valid0", rsp_valid0, 0);
        chk("rst_valid1", rsp_valid1, 0);
        chk("rst_rdata0", rsp_rdata0, 0);
        chk("rst_rdata1", rsp_rdata1, 0);
        chk("rst_perr0", rsp_perr0, 0);
        chk("rst_perr1", rsp_perr1, 0);
        m_ready = 1'b0;
        m_init_left = DEPTH;
        model_wipe();
        e0v = 0; e1v = 0; e0p = 0; e1p = 0;
        e0d = 8'h00; e1d = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock of stimulus, model update and output comparison
    task automatic step(input bit v, input bit we, input logic [3:0] a,
                        input logic [7:0] d, input bit inj, input bit clr);
        bit         exp_rdy, acc, oldp;
        logic [7:0] old;
        req_valid = v; req_we = we; req_addr = a;
        req_wdata = d; inj_perr = inj; clear_req = clr;
        #1;
        exp_rdy = m_ready && !clr;
        chk("req_ready0", req_ready0, exp_rdy);
        chk("req_ready1", req_ready1, exp_rdy);
        acc = v && exp_rdy;
        @(posedge clk);
        e0v = 0; e1v = 0; e0p = 0; e1p = 0;
        if (!m_ready) begin
            m_init_left--;
            if (m_init_left == 0) m_ready = 1'b1;
        end else if (clr) begin
            m_ready = 1'b0;
            m_init_left = DEPTH;
            model_wipe();
        end else if (acc) begin
            old  = m_mem[a];
            oldp = PAR && m_pinj[a];
            if (we) begin
                m_mem[a]  = d;
                m_pinj[a] = inj;
            end
            e1v = 1; e1d = old; e1p = oldp;
            if (!we) begin
                e0v = 1; e0d = old; e0p = oldp;
            end
        end
        #1;
        chk("init_busy0", init_busy0, !m_ready);
        chk("init_busy1", init_busy1, !m_ready);
        chk("rsp_valid0", rsp_valid0, e0v);
        chk("rsp_valid1", rsp_valid1, e1v);
        chk("rsp_rdata0", rsp_rdata0, e0d);
        chk("rsp_rdata1", rsp_rdata1, e1d);
        if (e0v) chk("rsp_perr0", rsp_perr0, e0p);
        if (e1v) chk("rsp_perr1", rsp_perr1, e1p);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        req_we = 0; req_addr = 0; req_wdata = 0; inj_perr = 0;
        tbl[0]  = '{1'b1, 4'h3, 8'hA5, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 4'h3, 8'h00, 1'b0, 8'hA5, 1'b0};
        tbl[2]  = '{1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{1'b1, 4'h7, 8'h11, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{1'b1, 4'h7, 8'h22, 1'b0, 8'h11, 1'b0};
        tbl[5]  = '{1'b0, 4'h7, 8'h00, 1'b0, 8'h22, 1'b0};
        tbl[6]  = '{1'b1, 4'h5, 8'h3C, 1'b1, 8'h00, 1'b0};
        tbl[7]  = '{1'b0, 4'h5, 8'h00, 1'b0, 8'h3C, 1'b1};
        tbl[8]  = '{1'b1, 4'hF, 8'h5A, 1'b0, 8'h00, 1'b0};
        tbl[9]  = '{1'b0, 4'hF, 8'h00, 1'b0, 8'h5A, 1'b0};
        tbl[10] = '{1'b0, 4'h5, 8'h00, 1'b0, 8'h3C, 1'b1};
        tbl[11] = '{1'b1, 4'h5, 8'h3C, 1'b0, 8'h3C, 1'b1};
        tbl[12] = '{1'b0, 4'h5, 8'h00, 1'b0, 8'h3C, 1'b0};

        // Power-on reset, then 16 clear cycles with a read held pending
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 0, 4'h9, 8'h00, 0, 0);
        step(1, 0, 4'h9, 8'h00, 0, 0);

        // Directed table on freshly cleared memory
        for (int i = 0; i < 13; i++) begin
            step(1, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].inj, 0);
            chk("tbl_valid1", rsp_valid1, 1);
            chk("tbl_rdata1", rsp_rdata1, tbl[i].rdata);
            chk("tbl_perr1", rsp_perr1, tbl[i].perr & PAR);
            chk("tbl_valid0", rsp_valid0, !tbl[i].we);
            if (!tbl[i].we) begin
                chk("tbl_rdata0", rsp_rdata0, tbl[i].rdata);
                chk("tbl_perr0", rsp_perr0, tbl[i].perr & PAR);
            end
        end

        // Write then read back-to-back returns new data
        step(1, 1, 4'h3, 8'hC3, 0, 0);
        step(1, 0, 4'h3, 8'h00, 0, 0);
        chk("wr_rd_next", rsp_rdata0, 8'hC3);

        // Fill with 0xFF, clear, verify all zero
        for (int i = 0; i < DEPTH; i++) step(1, 1, 4'(i), 8'hFF, 0, 0);
        step(1, 0, 4'h0, 8'h00, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 4'h2, 8'h00, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 4'(i), 8'h00, 0, 0);

        // Reset in the middle of a clear (clr_addr = 9)
        step(1, 1, 4'h4, 8'h77, 0, 0);
        step(1, 0, 4'h4, 8'h00, 0, 0);
        step(0, 0, 4'h0, 8'h00, 0, 1);
        for (int i = 0; i < 9; i++) step(0, 0, 4'h0, 8'h00, 0, 0);
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 0, 4'h1, 8'h00, 0, 0);
        step(1, 0, 4'h4, 8'h00, 0, 0);

        // Reset while a response is on the outputs
        step(1, 1, 4'h6, 8'h96, 0, 0);
        step(1, 0, 4'h6, 8'h00, 0, 0);
        chk("pre_rst_valid", rsp_valid0, 1);
        #1;
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(0, 0, 4'h0, 8'h00, 0, 0);
        step(1, 0, 4'h6, 8'h00, 0, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 8'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
